// File: rtl/reg_watch_checker.sv
// Register-file watch checker: shadows writes to watched addresses during a run,
// then compares the final shadow values against expected data (pass/fail/timeout).
module reg_watch_checker #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_WATCH   = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          start,
    input  logic                          done,
    input  logic                          strict,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr,
    input  logic [NUM_WATCH*DATA_W-1:0]   expect_data,
    output logic                          busy,
    output logic                          pass,
    output logic                          fail,
    output logic                          timeout,
    output logic [NUM_WATCH-1:0]          seen_mask,
    output logic [NUM_WATCH-1:0]          fail_mask,
    output logic [CNT_W-1:0]              cycle_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE_S} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    state_t               state_reg;
    logic                 strict_reg;
    logic [NUM_WATCH-1:0] hit;
    logic [NUM_WATCH-1:0] mismatch;
    logic                 launch;

    assign launch = ((state_reg == IDLE) || (state_reg == DONE_S)) && start;

    generate
        for (genvar gi = 0; gi < NUM_WATCH; gi++) begin : g_ch
            logic [DATA_W-1:0] shadow_reg;

            // Address 0 is never a real register, so it can never hit a channel.
            assign hit[gi] = wr_en && (wr_addr != '0)
                             && (watch_addr[gi*ADDR_W +: ADDR_W] == wr_addr);
            assign mismatch[gi] = (shadow_reg != expect_data[gi*DATA_W +: DATA_W])
                                  || (strict_reg && !seen_mask[gi]);

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    shadow_reg <= '0;
                end else if (launch) begin
                    shadow_reg <= '0;
                end else if ((state_reg == RUN) && hit[gi]) begin
                    shadow_reg <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= IDLE;
            strict_reg <= 1'b0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            seen_mask  <= '0;
            fail_mask  <= '0;
            cycle_cnt  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE_S: begin
                    if (start) begin
                        strict_reg <= strict;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        timeout    <= 1'b0;
                        seen_mask  <= '0;
                        fail_mask  <= '0;
                        cycle_cnt  <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    seen_mask <= seen_mask | hit;
                    // Saturate at the timeout limit so the count never wraps.
                    if (cycle_cnt != LAST_CNT) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    if (done) begin
                        state_reg <= CHECK;
                    end else if (cycle_cnt == LAST_CNT) begin
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE_S;
                    end
                end
                CHECK: begin
                    fail_mask <= mismatch;
                    pass      <= (mismatch == '0);
                    fail      <= (mismatch != '0);
                    busy      <= 1'b0;
                    state_reg <= DONE_S;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_watch_checker.md
REG_WATCH_CHECKER -- requirements
Module: reg_watch_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 SHALL have parameter NUM_WATCH, default 4: number of watched-register channels, range 1-8.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: maximum RUN cycles, range 2 to 2^CNT_W-1.
REQ-005 SHALL have parameter CNT_W, default 16: cycle-counter width.
REQ-006 SHALL have port sys_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: single-cycle request to begin a check run.
REQ-009 SHALL have port done, input, 1: program-finished indication.
REQ-010 SHALL have port strict, input, 1: unwritten-channel policy, sampled on start.
REQ-011 SHALL have port wr_en, input, 1: register-file write enable.
REQ-012 SHALL have port wr_addr, input, ADDR_W: register-file write address.
REQ-013 SHALL have port wr_data, input, DATA_W: register-file write data.
REQ-014 SHALL have port watch_addr, input, NUM_WATCH*ADDR_W: per-channel watched address; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-015 SHALL have port expect_data, input, NUM_WATCH*DATA_W: per-channel expected final value, same packing.
REQ-016 SHALL have port busy, output, 1: run in progress.
REQ-017 SHALL have port pass, output, 1: sticky pass result.
REQ-018 SHALL have port fail, output, 1: sticky mismatch result.
REQ-019 SHALL have port timeout, output, 1: sticky timeout result.
REQ-020 SHALL have port seen_mask, output, NUM_WATCH: channels written during the run.
REQ-021 SHALL have port fail_mask, output, NUM_WATCH: channels that mismatched.
REQ-022 SHALL have port cycle_cnt, output, CNT_W: RUN cycles elapsed.

Function
REQ-023 SHALL implement FSM states IDLE, RUN, CHECK, DONE_S.
REQ-024 SHALL, in IDLE or DONE_S with start=1, clear the shadow values, seen_mask, fail_mask, cycle_cnt, pass, fail and timeout, latch strict, and enter RUN on the next edge.
REQ-025 SHALL ignore start while in RUN or CHECK.
REQ-026 SHALL, in RUN on each cycle with wr_en=1 and wr_addr!=0, load wr_data into the shadow value of every channel whose watch_addr equals wr_addr and set that channel's seen bit; duplicate addresses update all matching channels.
REQ-027 SHALL ignore writes to address 0.
REQ-028 SHALL keep the last write within a run when a channel is written more than once.
REQ-029 SHALL increment cycle_cnt once per RUN cycle.
REQ-030 SHALL go from RUN to CHECK when done=1, and still capture a write presented in that same cycle.
REQ-031 SHALL go from RUN to DONE_S with timeout=1 when cycle_cnt reaches TIMEOUT_CYC-1 and done=0.
REQ-032 SHALL give done priority when done and the timeout condition occur in the same cycle.
REQ-033 SHALL, in CHECK, mark channel i mismatched if shadow != expected, or if strict=1 and the channel is unseen.
REQ-034 SHALL, in CHECK with strict=0, compare an unseen channel's shadow value (0) against its expected value.
REQ-035 SHALL, in CHECK, set fail_mask, set pass=1 if fail_mask is zero and fail=1 otherwise, then enter DONE_S; CHECK lasts exactly one cycle.
REQ-036 SHALL assert busy in RUN and CHECK only.
REQ-037 SHALL hold pass, fail, timeout, seen_mask, fail_mask and cycle_cnt stable in DONE_S until the next start.
REQ-038 SHALL keep pass, fail and timeout mutually exclusive.
REQ-039 SHALL not wrap cycle_cnt.

Reset
REQ-040 SHALL, on sys_rst_n=0 at any time including mid-run, immediately force the state to IDLE and all outputs and shadow values to 0.
REQ-041 SHALL start no new run after reset release until start is asserted.

Verification
REQ-042 SHALL cover a pass run: watch x1,x2,x29,x30, expect 5,5,1,0, strict=0; write x1=5, x2=5, x29=1; done -> pass=1, seen_mask=0111, fail_mask=0000.
REQ-043 SHALL cover strict mode: the same run with strict=1 -> fail=1, fail_mask=1000.
REQ-044 SHALL cover a repeated write: x1=3 then x1=5, expect 5 -> pass=1; x1=5 then x1=3 -> fail=1, fail_mask bit0=1.
REQ-045 SHALL cover timeout: TIMEOUT_CYC=8, done never asserted -> timeout=1 with cycle_cnt=7, and done arriving in the cycle cnt=7 -> CHECK path with no timeout.
REQ-046 SHALL cover same-cycle capture: write x2=9 in the same cycle as done, expect 9 -> pass=1; writes to x0 leave all seen bits at 0.
REQ-047 SHALL cover mid-run reset: sys_rst_n low during RUN -> all outputs 0 asynchronously; start afterwards -> clean run with cycle_cnt counting from 0.
